audio_dma_feeder: RTL

- Upstream feeder for the audio output FIFO stage, all in the clk_sys domain.
- Fetches packed stereo frames {left[15:0], right[15:0]} from a CPU-filled ring buffer in memory.
- Applies a master volume with saturation.
- Pushes one frame per sample_wr strobe into the audio FIFO, throttled by the FIFO write-side fill level.
- Exposes the ring read pointer so the CPU can manage the ring, plus a starvation counter.

---
 rtl/audio_dma_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/audio_dma_feeder.sv
// Ring-buffer fetcher for the audio output FIFO: reads packed stereo frames from memory,
// applies a saturating master volume and pushes one frame per sample_wr strobe.
module audio_dma_feeder #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned HIGH_WATER = 3072
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_len,
    input  logic [15:0]       cpu_wr_ptr,
    input  logic [8:0]        volume,
    output logic [15:0]       rd_ptr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              sample_wr,
    output logic [31:0]       sample_data,
    input  logic [11:0]       fifo_level,
    input  logic              fifo_full,
    output logic [15:0]       underrun_cnt
);

    typedef enum logic [2:0] {StIdle, StCheck, StReq, StWait, StScale, StPush} state_e;

    localparam logic [11:0] HighWaterLvl = 12'(HIGH_WATER);

    state_e      state_q, state_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] frame_q, frame_d;
    logic [31:0] sample_q, sample_d;
    logic        abort_q, abort_d;
    logic        starved, starved_q;
    logic [15:0] underrun_q;

    // Signed sample times unsigned 9-bit gain (256 = unity), floor shift by 8, clamp to 16 bits.
    function automatic logic [15:0] scale_ch(input logic [15:0] x, input logic [8:0] vol);
        logic signed [25:0] p;
        logic signed [17:0] s;
        p = $signed(x) * $signed({1'b0, vol});
        s = 18'(p >>> 8);
        if (s > 18'sd32767) begin
            return 16'h7fff;
        end else if (s < -18'sd32768) begin
            return 16'h8000;
        end
        return s[15:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        frame_d   = frame_q;
        sample_d  = sample_q;
        abort_d   = abort_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        sample_wr = 1'b0;
        unique case (state_q)
            StIdle: begin
                rd_ptr_d = '0;
                abort_d  = 1'b0;
                if (cfg_enable && cfg_len != 16'd0) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!cfg_enable || cfg_len == 16'd0) begin
                    rd_ptr_d = '0;
                    state_d  = StIdle;
                end else if (rd_ptr_q != cpu_wr_ptr && !fifo_full &&
                             fifo_level < HighWaterLvl) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req  = 1'b1;
                mem_addr = cfg_base + ADDR_W'(rd_ptr_q);
                // A disable during the handshake is remembered so the read is dropped later.
                if (!cfg_enable) begin
                    abort_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!cfg_enable) begin
                    abort_d = 1'b1;
                end
                if (mem_rvalid) begin
                    if (abort_q || !cfg_enable) begin
                        rd_ptr_d = '0;
                        abort_d  = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        frame_d = mem_rdata;
                        state_d = StScale;
                    end
                end
            end
            StScale: begin
                sample_d = {scale_ch(frame_q[31:16], volume), scale_ch(frame_q[15:0], volume)};
                state_d  = StPush;
            end
            StPush: begin
                sample_wr = 1'b1;
                rd_ptr_d  = (rd_ptr_q + 16'd1 == cfg_len) ? 16'd0 : rd_ptr_q + 16'd1;
                state_d   = StCheck;
            end
            default: state_d = StIdle;
        endcase
    end

    assign starved = cfg_enable && (state_q == StCheck) && (rd_ptr_q == cpu_wr_ptr) &&
                     (fifo_level == 12'd0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            frame_q    <= '0;
            sample_q   <= '0;
            abort_q    <= 1'b0;
            starved_q  <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            frame_q   <= frame_d;
            sample_q  <= sample_d;
            abort_q   <= abort_d;
            starved_q <= starved;
            if (starved && !starved_q && underrun_q != 16'hffff) begin
                underrun_q <= underrun_q + 16'd1;
            end
        end
    end

    assign rd_ptr       = rd_ptr_q;
    assign sample_data  = sample_q;
    assign underrun_cnt = underrun_q;

endmodule
